// File: rtl/slam_pkg.sv
// slam_pkg
// Shared definitions for the SLAM controller slice:
//   - ctrl_state_t : sequencer state encoding
//   - SCAN_ENTRIES : entries per scan (one position entry + measurements)
//   - NUM_SCANS    : scans stored in the scan memory
//   - ADDR_W       : scan address width covering every stored entry
//   - ack_timer_width() : timeout counter width for a given timeout
package slam_pkg;

    localparam int SCAN_ENTRIES = 721;
    localparam int NUM_SCANS    = 10;
    localparam int ADDR_W       = $clog2(SCAN_ENTRIES * NUM_SCANS + 1);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RESET_ADDR = 4'd1,
        ST_CLEAR      = 4'd2,
        ST_CLEAR_ACK  = 4'd3,
        ST_CLEAR_WAIT = 4'd4,
        ST_SETTLE     = 4'd5,
        ST_LOAD_POS   = 4'd6,
        ST_TRACE      = 4'd7,
        ST_TRACE_ACK  = 4'd8,
        ST_TRACE_WAIT = 4'd9,
        ST_ADVANCE    = 4'd10,
        ST_DISPLAY    = 4'd11,
        ST_DONE       = 4'd12,
        ST_ERROR      = 4'd13
    } ctrl_state_t;

    // At least 4 bits, wider if the timeout needs it.
    function automatic int ack_timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/slam_controller_ack_timer.sv
// ack_timer
// Acknowledge timeout counter shared by the CLEAR_ACK and TRACE_ACK waits.
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   load_i    : hold the counter at zero (asserted outside the ACK states,
//               so every ACK state starts from a fresh count)
//   count_i   : advance one step per cycle spent waiting
//   expired_o : this is the TIMEOUT-th waiting cycle; no further wait allowed
module ack_timer #(
    parameter int TIMEOUT = 15,
    parameter int WIDTH   = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (count_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/slam_controller.sv
// slam_controller
// Top-level sequencer for the SLAM data flow. Clears the occupancy grid,
// walks each scan (position entry, then measurements through the line
// tracer), hands the grid indices to the display between scans and stops
// after the last scan.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   start                    : run request (level in IDLE, rising edge in DONE)
//   scan_done                : current scan address is a scan boundary
//   simulation_done          : all scans consumed
//   bresenham_busy           : line tracer running
//   occupancy_busy           : grid clear/update in progress
//   vga_busy                 : display reading the grid
//   address_reset            : pulse, restart scan address
//   address_enable           : pulse, increment scan address
//   position_enable          : pulse, latch sensor position
//   bresenham_start          : pulse, trace current measurement
//   zero_occupancy_grid      : pulse, clear grid
//   use_bresenham_indices    : 1 = tracer owns grid indices, 0 = display
//   running, finished, error : run status flags
//   points_processed         : measurements traced in the current run
module slam_controller
    import slam_pkg::*;
#(
    parameter int READ_LATENCY       = 1,
    parameter int ACK_TIMEOUT        = 15,
    parameter int DISPLAY_MIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        scan_done,
    input  logic        simulation_done,
    input  logic        bresenham_busy,
    input  logic        occupancy_busy,
    input  logic        vga_busy,
    output logic        address_reset,
    output logic        address_enable,
    output logic        position_enable,
    output logic        bresenham_start,
    output logic        zero_occupancy_grid,
    output logic        use_bresenham_indices,
    output logic        running,
    output logic        finished,
    output logic        error,
    output logic [15:0] points_processed
);

    localparam int TMR_W = ack_timer_width(ACK_TIMEOUT);
    localparam int SET_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int DSP_W = (DISPLAY_MIN_CYCLES > 1) ? $clog2(DISPLAY_MIN_CYCLES) : 1;

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(READ_LATENCY - 1);
    localparam logic [DSP_W-1:0] DSP_LAST = DSP_W'(DISPLAY_MIN_CYCLES - 1);

    ctrl_state_t      state_q;
    ctrl_state_t      target_q;      // where SETTLE goes once data is valid
    logic [SET_W-1:0] settle_cnt_q;
    logic [DSP_W-1:0] disp_cnt_q;
    logic             start_prev_q;

    logic             address_reset_q;
    logic             address_enable_q;
    logic             position_enable_q;
    logic             bresenham_start_q;
    logic             zero_grid_q;
    logic             use_bres_q;
    logic             running_q;
    logic             finished_q;
    logic             error_q;
    logic [15:0]      points_q;

    logic             in_ack;
    logic             timer_expired;

    assign in_ack = (state_q == ST_CLEAR_ACK) || (state_q == ST_TRACE_ACK);

    ack_timer #(
        .TIMEOUT (ACK_TIMEOUT),
        .WIDTH   (TMR_W)
    ) u_ack_timer (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .load_i    (!in_ack),
        .count_i   (in_ack),
        .expired_o (timer_expired)
    );

    // Pulses are set on the transition into the state that owns them, so each
    // pulse is visible for exactly the one cycle the FSM spends there. The
    // exception is bresenham_start: it depends on scan_done sampled in TRACE,
    // so it shows up in the first TRACE_ACK cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            target_q          <= ST_LOAD_POS;
            settle_cnt_q      <= '0;
            disp_cnt_q        <= '0;
            start_prev_q      <= 1'b0;
            address_reset_q   <= 1'b0;
            address_enable_q  <= 1'b0;
            position_enable_q <= 1'b0;
            bresenham_start_q <= 1'b0;
            zero_grid_q       <= 1'b0;
            use_bres_q        <= 1'b1;
            running_q         <= 1'b0;
            finished_q        <= 1'b0;
            error_q           <= 1'b0;
            points_q          <= '0;
        end else begin
            address_reset_q   <= 1'b0;
            address_enable_q  <= 1'b0;
            position_enable_q <= 1'b0;
            bresenham_start_q <= 1'b0;
            zero_grid_q       <= 1'b0;
            start_prev_q      <= start;

            unique case (state_q)
                ST_IDLE: begin
                    points_q <= '0;
                    if (start) begin
                        state_q         <= ST_RESET_ADDR;
                        address_reset_q <= 1'b1;
                        running_q       <= 1'b1;
                    end
                end

                ST_RESET_ADDR: begin
                    state_q     <= ST_CLEAR;
                    zero_grid_q <= 1'b1;
                end

                ST_CLEAR: begin
                    state_q <= ST_CLEAR_ACK;
                end

                ST_CLEAR_ACK: begin
                    if (occupancy_busy) begin
                        state_q <= ST_CLEAR_WAIT;
                    end else if (timer_expired) begin
                        state_q   <= ST_ERROR;
                        running_q <= 1'b0;
                        error_q   <= 1'b1;
                    end
                end

                ST_CLEAR_WAIT: begin
                    if (!occupancy_busy) begin
                        state_q      <= ST_SETTLE;
                        target_q     <= ST_LOAD_POS;
                        settle_cnt_q <= '0;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == SET_LAST) begin
                        state_q <= target_q;
                        if (target_q == ST_LOAD_POS) begin
                            position_enable_q <= 1'b1;
                            address_enable_q  <= 1'b1;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end

                ST_LOAD_POS: begin
                    state_q      <= ST_SETTLE;
                    target_q     <= ST_TRACE;
                    settle_cnt_q <= '0;
                end

                ST_TRACE: begin
                    // A boundary means the measurements of this scan are used
                    // up; no trace is started for the boundary entry.
                    if (scan_done) begin
                        state_q    <= ST_DISPLAY;
                        use_bres_q <= 1'b0;
                        disp_cnt_q <= '0;
                    end else begin
                        state_q           <= ST_TRACE_ACK;
                        bresenham_start_q <= 1'b1;
                    end
                end

                ST_TRACE_ACK: begin
                    if (bresenham_busy) begin
                        state_q <= ST_TRACE_WAIT;
                    end else if (timer_expired) begin
                        state_q   <= ST_ERROR;
                        running_q <= 1'b0;
                        error_q   <= 1'b1;
                    end
                end

                ST_TRACE_WAIT: begin
                    // The tracer's last grid write may still be in flight.
                    if (!bresenham_busy && !occupancy_busy) begin
                        state_q          <= ST_ADVANCE;
                        address_enable_q <= 1'b1;
                    end
                end

                ST_ADVANCE: begin
                    if (points_q != 16'hFFFF) begin
                        points_q <= points_q + 16'd1;
                    end
                    state_q      <= ST_SETTLE;
                    target_q     <= ST_TRACE;
                    settle_cnt_q <= '0;
                end

                ST_DISPLAY: begin
                    if (disp_cnt_q != DSP_LAST) begin
                        disp_cnt_q <= disp_cnt_q + 1'b1;
                    end else if (!vga_busy) begin
                        use_bres_q <= 1'b1;
                        if (simulation_done) begin
                            state_q    <= ST_DONE;
                            running_q  <= 1'b0;
                            finished_q <= 1'b1;
                        end else begin
                            // The boundary entry is the next scan's position.
                            state_q           <= ST_LOAD_POS;
                            position_enable_q <= 1'b1;
                            address_enable_q  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (start && !start_prev_q) begin
                        state_q         <= ST_RESET_ADDR;
                        address_reset_q <= 1'b1;
                        finished_q      <= 1'b0;
                        running_q       <= 1'b1;
                        points_q        <= '0;
                    end
                end

                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    use_bres_q <= 1'b1;
                    running_q  <= 1'b0;
                    finished_q <= 1'b0;
                    error_q    <= 1'b0;
                end
            endcase
        end
    end

    assign address_reset         = address_reset_q;
    assign address_enable        = address_enable_q;
    assign position_enable       = position_enable_q;
    assign bresenham_start       = bresenham_start_q;
    assign zero_occupancy_grid   = zero_grid_q;
    assign use_bresenham_indices = use_bres_q;
    assign running               = running_q;
    assign finished              = finished_q;
    assign error                 = error_q;
    assign points_processed      = points_q;

endmodule

// File: doc/slam_controller.md
# slam_controller

Top-level sequencer for the SLAM data flow: drives the scan-address, position-register, Bresenham-start, grid-clear and index-mux controls of the data flow block, and consumes its `scan_done`, `simulation_done` and busy flags. It clears the occupancy grid, walks each scan (one position entry, then measurements), hands the grid indices to the display between scans, and stops after the last scan. It sits beside the data flow block in the top level.

## Interface
Parameters:
- `READ_LATENCY`, 1: cycles from scan address change to valid scan data.
- `ACK_TIMEOUT`, 15: cycles allowed for a busy flag to rise after its start pulse.
- `DISPLAY_MIN_CYCLES`, 4: minimum cycles the display owns the grid indices per scan.

Ports:
- `clock` in 1: system clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled in IDLE and begins a run.
- `scan_done` in 1: current address is a scan boundary.
- `simulation_done` in 1: all scans consumed.
- `bresenham_busy` in 1: line tracer running.
- `occupancy_busy` in 1: grid busy (clear or update).
- `vga_busy` in 1: display reading grid.
- `address_reset` out 1: one-cycle pulse, restarts scan address.
- `address_enable` out 1: one-cycle pulse, increments scan address.
- `position_enable` out 1: one-cycle pulse, latches sensor position.
- `bresenham_start` out 1: one-cycle pulse, traces current measurement.
- `zero_occupancy_grid` out 1: one-cycle pulse, clears grid.
- `use_bresenham_indices` out 1: 1 = tracer owns grid indices, 0 = display.
- `running` out 1: high in any state other than IDLE, DONE and ERROR.
- `finished` out 1: high in DONE.
- `error` out 1: high in ERROR (ack timeout).
- `points_processed` out 16: measurements traced since the last run started.

## Operation
- States: IDLE, RESET_ADDR, CLEAR, CLEAR_ACK, CLEAR_WAIT, SETTLE, LOAD_POS, TRACE, TRACE_ACK, TRACE_WAIT, ADVANCE, DISPLAY, DONE, ERROR.
- IDLE: `start`=1 -> RESET_ADDR. Clears `points_processed`.
- RESET_ADDR: pulse `address_reset` -> CLEAR.
- CLEAR: pulse `zero_occupancy_grid` -> CLEAR_ACK.
- CLEAR_ACK: wait for `occupancy_busy`=1 -> CLEAR_WAIT. Timeout -> ERROR.
- CLEAR_WAIT: wait for `occupancy_busy`=0 -> SETTLE with a next-target of LOAD_POS.
- SETTLE: wait `READ_LATENCY` cycles, then go to the next-target state. The next-target is LOAD_POS or TRACE.
- LOAD_POS: pulse `position_enable` and `address_enable` in the same cycle. The position register samples the pre-increment data. -> SETTLE with a next-target of TRACE.
- TRACE:
  - If `scan_done`=1: no pulse -> DISPLAY. Precedence: the boundary is checked before the start pulse.
  - Otherwise: pulse `bresenham_start` -> TRACE_ACK.
- TRACE_ACK: wait for `bresenham_busy`=1 -> TRACE_WAIT. Timeout -> ERROR.
- TRACE_WAIT: wait for `bresenham_busy`=0 and `occupancy_busy`=0 -> ADVANCE.
- ADVANCE: pulse `address_enable`; `points_processed`+=1, saturating at 16'hFFFF. -> SETTLE with a next-target of TRACE.
- DISPLAY:
  - `use_bresenham_indices`=0.
  - Stay at least `DISPLAY_MIN_CYCLES` cycles and until `vga_busy`=0.
  - Then `simulation_done`=1 -> DONE; else -> LOAD_POS. The boundary address is the next scan's position entry.
- DONE: hold; `start` rising edge (0 in the previous cycle, 1 now) -> RESET_ADDR.
- ERROR: hold until reset.
- `use_bresenham_indices`=1 in every state except DISPLAY.
- Timeout counter: 4 bits minimum, sized for `ACK_TIMEOUT`. Reloaded on entry to each *_ACK state. ERROR is entered when the counter reaches `ACK_TIMEOUT` with the awaited flag still low.
- The busy flag is sampled at the clock edge. If busy is already high on the first ACK cycle, the ACK state advances after 1 cycle.

## Timing
- Reset values:
  - state IDLE.
  - All pulses 0.
  - `use_bresenham_indices`=1, `running`=0, `finished`=0, `error`=0, `points_processed`=0.
- All outputs are registered, so each pulse is exactly one cycle wide.
- At most one of `address_enable`, `bresenham_start`, `zero_occupancy_grid` or `address_reset` is high in any cycle. The one exception is `position_enable` together with `address_enable`.
- Per-measurement overhead excluding trace time: TRACE + ACK(≥1) + ADVANCE + `READ_LATENCY` ≈ 4 cycles at `READ_LATENCY`=1.
- `reset_n` low mid-run forces IDLE immediately; all pulses drop asynchronously.
- `start` held high during a run is ignored.

## Structure
- Package `slam_pkg`: state enum `ctrl_state_t`, `SCAN_ENTRIES`=721, `NUM_SCANS`=10, and a shared address width.
- One sub-module, `ack_timer`: load/count/expired timeout counter reused by CLEAR_ACK and TRACE_ACK.
- The rest is a single FSM with registered outputs.

## Test plan
- Reset: hold `reset_n`=0 -> all outputs at reset values; `use_bresenham_indices`=1.
- Clear: `start`=1, model clears 5 cycles -> `address_reset`, then `zero_occupancy_grid` pulse. No `position_enable` until `occupancy_busy` has fallen and 1 settle cycle has passed.
- Single-scan model: 721 entries, tracer busy 3 cycles -> 720 `bresenham_start` pulses and `points_processed`=720. DISPLAY is entered; `use_bresenham_indices`=0 for ≥4 cycles.
- Ten scans with `simulation_done` asserted after the tenth -> `finished`=1, `points_processed`=7200, 10 `position_enable` pulses.
- Tracer never raises busy -> `error`=1 `ACK_TIMEOUT` cycles after the first `bresenham_start`; all pulses remain 0 afterwards.
- `reset_n` pulsed low mid-trace -> IDLE next edge, `running`=0. A fresh `start` restarts from `address_reset`.
